// File: rtl/dmem_access_unit.sv
// MEM-stage load/store unit: turns EX/MEM load/store requests into word-aligned,
// byte-enabled req/ack memory transactions and freezes the pipeline until they complete.
module dmem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_x,
  input  logic        Mi_memRead,
  input  logic        Mi_memWrite,
  input  logic [1:0]  Mi_memSize,
  input  logic [31:0] Mi_addr,
  input  logic [31:0] Mi_writeData,
  output logic [31:0] Mo_readData,
  output logic        Mo_stall,
  output logic        Mo_misaligned,
  output logic        Mo_busError,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_DONE
  } state_e;

  localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] rdata_q, rdata_d;
  logic        bus_err_q, bus_err_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;

  logic        access;
  logic        misaligned;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;

  assign access = Mi_memRead | Mi_memWrite;

  // Lane decode; size 11 behaves exactly like a word access.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    misaligned = 1'b0;
    be_c       = 4'b1111;
    wdata_c    = Mi_writeData;
    case (Mi_memSize)
      2'b00: begin
        be_c    = 4'b0001 << Mi_addr[1:0];
        wdata_c = {4{Mi_writeData[7:0]}};
      end
      2'b01: begin
        misaligned = Mi_addr[0];
        be_c       = 4'b0011 << Mi_addr[1:0];
        wdata_c    = {2{Mi_writeData[15:0]}};
      end
      default: begin
        misaligned = (Mi_addr[1:0] != 2'b00);
      end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    off_d     = off_q;
    rdata_d   = rdata_q;
    bus_err_d = 1'b0;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (access && !misaligned) begin
          req_d   = 1'b1;
          we_d    = Mi_memWrite;
          addr_d  = {Mi_addr[31:2], 2'b00};
          be_d    = be_c;
          wdata_d = wdata_c;
          off_d   = Mi_addr[1:0];
          cnt_d   = '0;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        // A completion on the last allowed cycle wins over the timeout.
        if (mem_ack) begin
          req_d = 1'b0;
          if (!we_q) rdata_d = mem_rdata >> {off_q, 3'b000};
          state_d = ST_DONE;
        end else if (cnt_q == LAST_WAIT) begin
          req_d     = 1'b0;
          rdata_d   = '0;
          bus_err_d = 1'b1;
          state_d   = ST_DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      off_q     <= '0;
      rdata_q   <= '0;
      bus_err_q <= 1'b0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      off_q     <= off_d;
      rdata_q   <= rdata_d;
      bus_err_q <= bus_err_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
    end
  end

  assign Mo_stall      = ((state_q == ST_IDLE) && access && !misaligned) || (state_q == ST_REQ);
  assign Mo_misaligned = (state_q == ST_IDLE) && access && misaligned;
  assign Mo_readData   = rdata_q;
  assign Mo_busError   = bus_err_q;
  assign mem_req       = req_q;
  assign mem_we        = we_q;
  assign mem_addr      = addr_q;
  assign mem_be        = be_q;
  assign mem_wdata     = wdata_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Scoreboard bench for dmem_access_unit: expected transactions are queued when an access
// is driven and compared when the unit raises mem_req; load data is checked at release.
module tb_dmem_access_unit;

  logic        clk = 1'b0;
  logic        reset_x;
  logic        Mi_memRead, Mi_memWrite;
  logic [1:0]  Mi_memSize;
  logic [31:0] Mi_addr, Mi_writeData;
  logic [31:0] Mo_readData;
  logic        Mo_stall, Mo_misaligned, Mo_busError;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } txn_t;

  txn_t        exp_q[$];
  logic [31:0] model_rd;

  always #5 clk = ~clk;

  dmem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk          (clk),
    .reset_x      (reset_x),
    .Mi_memRead   (Mi_memRead),
    .Mi_memWrite  (Mi_memWrite),
    .Mi_memSize   (Mi_memSize),
    .Mi_addr      (Mi_addr),
    .Mi_writeData (Mi_writeData),
    .Mo_readData  (Mo_readData),
    .Mo_stall     (Mo_stall),
    .Mo_misaligned(Mo_misaligned),
    .Mo_busError  (Mo_busError),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_be       (mem_be),
    .mem_wdata    (mem_wdata),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata)
  );

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  task automatic drop_inputs();
    Mi_memRead  = 1'b0;
    Mi_memWrite = 1'b0;
    Mi_memSize  = 2'b00;
    Mi_addr     = '0;
    Mi_writeData = '0;
  endtask

  // Queue the expected bus transaction for an aligned access (bench-side lane model).
  task automatic push_expected(input logic rd, input logic wr, input logic [1:0] sz,
                               input logic [31:0] addr, input logic [31:0] wd);
    txn_t t;
    t.we   = wr;
    t.addr = {addr[31:2], 2'b00};
    case (sz)
      2'b00: begin
        t.be = (addr[1:0] == 2'd0) ? 4'b0001 : (addr[1:0] == 2'd1) ? 4'b0010 :
               (addr[1:0] == 2'd2) ? 4'b0100 : 4'b1000;
        t.wdata = {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
      end
      2'b01: begin
        t.be    = addr[1] ? 4'b1100 : 4'b0011;
        t.wdata = {wd[15:0], wd[15:0]};
      end
      default: begin
        t.be    = 4'b1111;
        t.wdata = wd;
      end
    endcase
    if (rd && !wr) model_rd = 32'hxxxxxxxx;
    exp_q.push_back(t);
  endtask

  // Drive one access at a negedge and serve it with 'waits' wait cycles before ack.
  task automatic run_access(input string name, input logic rd, input logic wr,
                            input logic [1:0] sz, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [31:0] rdata,
                            input int waits, input logic [31:0] exp_rd);
    int   stall_n = 0;
    int   req_n   = 0;
    bit   done    = 0;
    txn_t t;
    push_expected(rd, wr, sz, addr, wd);
    Mi_memRead = rd; Mi_memWrite = wr; Mi_memSize = sz; Mi_addr = addr; Mi_writeData = wd;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      #1;
      if (Mo_stall) stall_n++;
      if (mem_req) begin
        req_n++;
        if (req_n == 1) begin
          if (exp_q.size() == 0) begin
            cmp({name, " unexpected_req"}, 32'd1, 32'd0);
          end else begin
            t = exp_q.pop_front();
            cmp({name, " mem_we"},    {31'd0, mem_we}, {31'd0, t.we});
            cmp({name, " mem_addr"},  mem_addr, t.addr);
            cmp({name, " mem_be"},    {28'd0, mem_be}, {28'd0, t.be});
            cmp({name, " mem_wdata"}, mem_wdata, t.wdata);
          end
        end
        mem_ack   = (req_n == waits + 1);
        mem_rdata = mem_ack ? rdata : 32'h0;
      end else begin
        mem_ack = 1'b0;
        if (!Mo_stall && req_n > 0) begin
          model_rd = exp_rd;
          cmp({name, " readData"}, Mo_readData, model_rd);
          cmp({name, " stall_cycles"}, stall_n, waits + 2);
          cmp({name, " busError"}, {31'd0, Mo_busError}, 32'd0);
          drop_inputs();
          done = 1;
        end
      end
      if (!done) @(negedge clk);
    end
    if (!done) cmp({name, " completion_timeout"}, 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_x = 1'b0;
    drop_inputs();
    mem_ack = 1'b0; mem_rdata = '0;
    model_rd = '0;
    repeat (2) @(negedge clk);
    #1;
    cmp("reset readData", Mo_readData, 32'h0);
    cmp("reset req_we",   {30'd0, mem_req, mem_we}, 32'h0);
    cmp("reset addr",     mem_addr, 32'h0);
    cmp("reset be_err",   {27'd0, mem_be, Mo_busError}, 32'h0);
    cmp("reset wdata",    mem_wdata, 32'h0);
    cmp("reset stall",    {31'd0, Mo_stall}, 32'h0);
    @(negedge clk);
    reset_x = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_word_load();
    run_access("word_load", 1'b1, 1'b0, 2'b10, 32'h100, 32'h0, 32'hDEADBEEF, 0, 32'hDEADBEEF);
  endtask

  task automatic test_byte_store();
    run_access("byte_store", 1'b0, 1'b1, 2'b00, 32'h103, 32'h0000_00A5, 32'h5555_5555, 3,
               32'hDEADBEEF);
  endtask

  task automatic test_half_load();
    run_access("half_load", 1'b1, 1'b0, 2'b01, 32'h202, 32'h0, 32'h12345678, 1, 32'h00001234);
  endtask

  task automatic test_misaligned();
    logic saw_req = 1'b0;
    Mi_memRead = 1'b1; Mi_memSize = 2'b01; Mi_addr = 32'h201;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (mem_req) saw_req = 1'b1;
      cmp("misaligned flag",  {31'd0, Mo_misaligned}, 32'd1);
      cmp("misaligned stall", {31'd0, Mo_stall}, 32'd0);
      @(negedge clk);
    end
    cmp("misaligned no_req", {31'd0, saw_req}, 32'd0);
    Mi_memSize = 2'b10; Mi_addr = 32'h106;
    #1;
    cmp("misaligned word flag", {31'd0, Mo_misaligned}, 32'd1);
    drop_inputs();
    #1;
    cmp("misaligned idle clear", {31'd0, Mo_misaligned}, 32'd0);
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int req_n = 0;
    int guard = 0;
    push_expected(1'b1, 1'b0, 2'b10, 32'h300, 32'h0);
    Mi_memRead = 1'b1; Mi_memSize = 2'b10; Mi_addr = 32'h300;
    mem_ack = 1'b0;
    @(negedge clk);
    void'(exp_q.pop_front());
    while (mem_req && guard < 20) begin
      req_n++; guard++;
      @(negedge clk);
    end
    #1;
    cmp("timeout req_cycles", req_n, 4);
    cmp("timeout busError",   {31'd0, Mo_busError}, 32'd1);
    cmp("timeout readData",   Mo_readData, 32'h0);
    cmp("timeout stall",      {31'd0, Mo_stall}, 32'd0);
    model_rd = '0;
    drop_inputs();
    @(negedge clk); #1;
    cmp("timeout pulse_end",  {31'd0, Mo_busError}, 32'd0);
    cmp("timeout idle",       {30'd0, mem_req, Mo_stall}, 32'd0);
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    push_expected(1'b1, 1'b0, 2'b10, 32'h400, 32'h0);
    Mi_memRead = 1'b1; Mi_memSize = 2'b10; Mi_addr = 32'h400;
    @(negedge clk);
    void'(exp_q.pop_front());
    cmp("rstmid in_req", {31'd0, mem_req}, 32'd1);
    @(negedge clk);
    reset_x = 1'b0;
    drop_inputs();
    #1;
    cmp("rstmid req_drop", {31'd0, mem_req}, 32'd0);
    cmp("rstmid stall",    {31'd0, Mo_stall}, 32'd0);
    model_rd = '0;
    @(negedge clk);
    reset_x = 1'b1;
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    cmp("rstmid late_ack", {30'd0, mem_req, Mo_stall}, 32'd0);
    cmp("rstmid readData", Mo_readData, model_rd);
    @(negedge clk);
    run_access("rstmid next_load", 1'b1, 1'b0, 2'b00, 32'h401, 32'h0, 32'hCAFEF00D, 0,
               32'h00CAFEF0);
  endtask

  task automatic test_rw_both();
    mem_ack = 1'b1; mem_rdata = 32'h11111111;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    cmp("spurious_ack idle", {30'd0, mem_req, Mo_stall}, 32'd0);
    @(negedge clk);
    run_access("rw_both", 1'b1, 1'b1, 2'b10, 32'h8, 32'h87654321, 32'h22222222, 0,
               32'h00CAFEF0);
  endtask

  task automatic test_back_to_back();
    run_access("b2b half_store", 1'b0, 1'b1, 2'b01, 32'h502, 32'h0000BEEF, 32'h0, 2,
               32'h00CAFEF0);
    run_access("b2b size11_load", 1'b1, 1'b0, 2'b11, 32'h504, 32'h0, 32'hA1B2C3D4, 1,
               32'hA1B2C3D4);
    run_access("b2b byte_load", 1'b1, 1'b0, 2'b00, 32'h506, 32'h0, 32'hA1B2C3D4, 0,
               32'h0000A1B2);
  endtask

  initial begin
    #2;
    test_reset();
    test_word_load();
    test_byte_store();
    test_half_load();
    test_misaligned();
    test_timeout();
    test_reset_mid();
    test_rw_both();
    test_back_to_back();
    cmp("scoreboard empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_access_unit.md
Name: dmem_access_unit

Overview:
- MEM-stage load/store unit between the pipeline datapath and a multi-cycle data memory with a req/ack handshake.
- Consumes the EX/MEM address and store data plus the controller's MEM-stage size and read/write strobes.
- Drives word-aligned, byte-enabled memory transactions and returns lane-aligned load data to the read-data extender.
- Freezes the pipeline while a transaction is outstanding, and flags misaligned accesses and bus timeouts.

Parameters:
TIMEOUT_CYCLES, 255, max cycles in REQ without mem_ack before a bus error (1..65535)

Ports:
clk  in  1  clock, rising edge
reset_x  in  1  asynchronous active-low reset
Mi_memRead  in  1  MEM-stage instruction is a load
Mi_memWrite  in  1  MEM-stage instruction is a store
Mi_memSize  in  2  00 byte, 01 half, 10 word, 11 treated as word
Mi_addr  in  32  byte address (ALU result)
Mi_writeData  in  32  store data, right-aligned
Mo_readData  out  32  load word shifted right by 8*addr[1:0]
Mo_stall  out  1  to hazard unit: freeze all pipeline registers and PC
Mo_misaligned  out  1  misaligned access this cycle, no transaction issued
Mo_busError  out  1  one-cycle pulse: access timed out
mem_req  out  1  transaction request, registered
mem_we  out  1  1 = write
mem_addr  out  32  {Mi_addr[31:2],2'b00}, registered
mem_be  out  4  byte enables, registered
mem_wdata  out  32  lane-replicated store data, registered
mem_ack  in  1  memory completion, valid only while mem_req=1
mem_rdata  in  32  read data, valid with mem_ack

Behaviour:
- Reset (async, reset_x=0): state IDLE, timeout counter 0, Mo_readData=0, mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0, Mo_busError=0.
- Reset mid-transaction aborts immediately with no completion. An ack arriving after reset is ignored.
- access = Mi_memRead | Mi_memWrite. If both are set, the access is a write.
- misaligned (combinational): half with addr[0]=1, or word/size 11 with addr[1:0]!=0.
- Mo_misaligned = IDLE & access & misaligned. Mo_misaligned is 0 in all other states.
- Mo_stall (combinational) = (IDLE & access & ~misaligned) | REQ.
- Byte enables: byte = 4'b0001<<addr[1:0]; half = 4'b0011<<addr[1:0]; word = 4'b1111.
- Write data: byte = {4{wd[7:0]}}; half = {2{wd[15:0]}}; word = wd.
- Read data: Mo_readData is loaded with mem_rdata >> (8*addr[1:0]) on the ack edge. The address offset is held in a register captured at issue.
- FSM states:
  - IDLE: on access & ~misaligned, register mem_addr/mem_be/mem_wdata/mem_we, set mem_req=1, clear the counter, go to REQ. On misaligned, stay in IDLE with no request. With no access, stay in IDLE. mem_ack in IDLE is ignored.
  - REQ: mem_req held 1 and all mem_* outputs stable. On mem_ack: mem_req=0; on a read, capture Mo_readData; go to DONE. Otherwise increment the counter. When counter==TIMEOUT_CYCLES-1 without ack: mem_req=0, Mo_readData=0, Mo_busError=1 next cycle, go to DONE.
  - DONE: Mo_stall=0, so the pipeline advances and the MEM/WB register captures Mo_readData. Mo_busError is cleared after this cycle. Go to IDLE unconditionally; the new MEM instruction is evaluated there the following cycle.
- Stores leave Mo_readData unchanged.
- Latency: zero-wait ack gives IDLE → REQ → DONE, i.e. 2 stall cycles plus the release cycle. Each wait cycle adds one stall cycle.
- Back-to-back accesses always pass through DONE and IDLE; there are no overlapping transactions.
- No combinational path from mem_ack to any mem_* output. Mo_stall depends only on state and the Mi_* inputs.

Test Plan:
- Word load, addr=0x100, ack on the first REQ cycle, rdata=0xDEADBEEF → mem_addr=0x100, be=1111, we=0. Stall high for 2 cycles. In DONE, Mo_readData=0xDEADBEEF and stall=0.
- Byte store, addr=0x103, wd=0x000000A5, ack after 3 wait cycles → be=1000, wdata=0xA5A5A5A5, we=1. Stall high for 5 cycles. Mo_readData unchanged.
- Half load, addr=0x202, rdata=0x12345678 → be=1100, Mo_readData=0x00001234. Half load at addr=0x201 → Mo_misaligned=1, mem_req never asserts, stall=0.
- TIMEOUT_CYCLES=4, mem_ack held 0 → mem_req drops after 4 REQ cycles. Mo_busError pulses exactly 1 cycle in DONE with Mo_readData=0. FSM returns to IDLE.
- Assert reset_x=0 in the 2nd REQ cycle → mem_req=0 and stall=0 immediately. An ack pulsed after release causes no state change. The next load completes normally.
- Read and write both set, addr=0x8, size=10 → treated as a store (we=1). A spurious ack in IDLE is ignored.
